// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared FSM encoding and byte width for the UART arbiter slice.
package uart_tx_arbiter_pkg;
    localparam int BYTE_W = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, LOAD = 2'd2} state_e;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte streams plus the uart_tx load handshake.
interface uart_tx_arbiter_if #(parameter int N_REQ = 4);
    import uart_tx_arbiter_pkg::*;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*BYTE_W-1:0] req_byte;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic                    tx_start;
    logic [BYTE_W-1:0]       tx_byte;
    logic                    tx_ready;
    logic                    tx_accept;
    modport master (
        input  req_valid, req_byte, req_last, tx_ready, tx_accept,
        output req_ready, tx_start, tx_byte
    );
    modport slave (
        output req_valid, req_byte, req_last, tx_ready, tx_accept,
        input  req_ready, tx_start, tx_byte
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational first-valid search starting at rr_ptr, wrapping.
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_valid,
    input  logic [$clog2(N)-1:0] rr_ptr,
    output logic [N-1:0]         pick,
    output logic [$clog2(N)-1:0] pick_idx
);
    int j;
    always_comb begin
        pick = '0;
        pick_idx = '0;
        j = 0;
        // Scan farthest offset first so the nearest valid requester overwrites.
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(rr_ptr) + k) % N;
            if (req_valid[j]) begin
                pick = N'(1) << j;
                pick_idx = $clog2(N)'(j);
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin sharing of one uart_tx between N_REQ
// byte-stream requesters, with an idle timeout that drops a stalled lock.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rstn,
    uart_tx_arbiter_if.master        bus,
    output logic [N_REQ-1:0]         grant,
    output logic                     err_timeout,
    output logic [$clog2(N_REQ)-1:0] err_id
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d, pick, req_ready;
    logic [IW-1:0]      owner_q, owner_d, rr_q, rr_d, pick_idx, owner_nxt;
    logic [BYTE_W-1:0]  byte_q, byte_d;
    logic               last_q, last_d, tx_start_q, tx_start_d, owner_valid;
    logic [CW-1:0]      cnt_q, cnt_d;

    rr_picker #(.N(N_REQ)) u_pick (
        .req_valid(bus.req_valid),
        .rr_ptr   (rr_q),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    assign owner_nxt   = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign owner_valid = bus.req_valid[owner_q];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        rr_d = rr_q;
        byte_d = byte_q;
        last_d = last_q;
        cnt_d = '0;
        req_ready = '0;
        err_timeout = 1'b0;
        case (state_q)
            IDLE: if (|bus.req_valid) begin
                grant_d = pick;
                owner_d = pick_idx;
                state_d = FETCH;
            end
            FETCH: begin
                req_ready = bus.tx_ready ? grant_q : '0;
                // Counter only advances while the owner has nothing to offer.
                if (owner_valid && bus.tx_ready) begin
                    byte_d = bus.req_byte[int'(owner_q)*BYTE_W +: BYTE_W];
                    last_d = bus.req_last[owner_q];
                    state_d = LOAD;
                end else if (owner_valid) begin
                    cnt_d = cnt_q;
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    err_timeout = 1'b1;
                    rr_d = owner_nxt;
                    grant_d = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOAD: if (bus.tx_accept) begin
                state_d = last_q ? IDLE : FETCH;
                rr_d = last_q ? owner_nxt : rr_q;
                grant_d = last_q ? '0 : grant_q;
            end
            default: state_d = IDLE;
        endcase
        tx_start_d = state_d == LOAD;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            rr_q <= '0;
            byte_q <= '0;
            last_q <= 1'b0;
            cnt_q <= '0;
            tx_start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            rr_q <= rr_d;
            byte_q <= byte_d;
            last_q <= last_d;
            cnt_q <= cnt_d;
            tx_start_q <= tx_start_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_byte   = tx_start_q ? byte_q : '0;
    assign grant         = grant_q;
    assign err_id        = err_timeout ? owner_q : '0;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: cycle table for one packet, then directed rotation, lock,
// timeout, reset-in-LOAD and stall sequences against hand-derived expectations.
module tb_uart_tx_arbiter;
    logic       clk, rstn;
    logic [3:0] grant;
    logic       err_timeout;
    logic [1:0] err_id;
    int         n_chk = 0, n_fail = 0;

    uart_tx_arbiter_if #(.N_REQ(4)) bus ();

    uart_tx_arbiter #(.N_REQ(4), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus.master),
        .grant      (grant),
        .err_timeout(err_timeout),
        .err_id     (err_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid, last;
        logic [7:0] din;
        logic       rdy, acc;
        logic [3:0] grant, ready;
        logic       start;
        logic [7:0] dout;
        logic       err;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
    endtask

    task automatic wait_grant(input string name, input logic [3:0] exp);
        for (int i = 0; i < 10 && grant == 4'b0; i++) step();
        chk(name, grant, exp);
    endtask

    task automatic xfer(input string name, input logic [7:0] exp);
        for (int i = 0; i < 10 && !bus.tx_start; i++) step();
        chk({name, "_start"}, bus.tx_start, 1);
        chk({name, "_byte"}, bus.tx_byte, exp);
        bus.tx_accept = 1'b1;
        step();
        bus.tx_accept = 1'b0;
    endtask

    initial begin
        logic bad_rdy, bad_err, any_start;
        tbl[0] = '{4'b0010, 4'b0000, 8'h55, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{4'b0010, 4'b0000, 8'h55, 1'b1, 1'b0, 4'b0010, 4'b0010, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{4'b0010, 4'b0010, 8'hA3, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b1, 8'h55, 1'b0};
        tbl[3] = '{4'b0010, 4'b0010, 8'hA3, 1'b0, 1'b1, 4'b0010, 4'b0000, 1'b1, 8'h55, 1'b0};
        tbl[4] = '{4'b0010, 4'b0010, 8'hA3, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 8'h00, 1'b0};
        tbl[5] = '{4'b0010, 4'b0010, 8'hA3, 1'b1, 1'b0, 4'b0010, 4'b0010, 1'b0, 8'h00, 1'b0};
        tbl[6] = '{4'b0000, 4'b0000, 8'h00, 1'b0, 1'b1, 4'b0010, 4'b0000, 1'b1, 8'hA3, 1'b0};
        tbl[7] = '{4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};

        rstn = 1'b0;
        bus.req_valid = '0;
        bus.req_last = '0;
        bus.req_byte = '0;
        bus.tx_ready = 1'b1;
        bus.tx_accept = 1'b0;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_start", bus.tx_start, 0);
        chk("rst_byte", bus.tx_byte, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_err_id", err_id, 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            bus.req_valid = tbl[i].valid;
            bus.req_last = tbl[i].last;
            bus.req_byte = {4{tbl[i].din}};
            bus.tx_ready = tbl[i].rdy;
            bus.tx_accept = tbl[i].acc;
            #1;
            chk($sformatf("pkt%0d_grant", i), grant, tbl[i].grant);
            chk($sformatf("pkt%0d_ready", i), bus.req_ready, tbl[i].ready);
            chk($sformatf("pkt%0d_start", i), bus.tx_start, tbl[i].start);
            chk($sformatf("pkt%0d_byte", i), bus.tx_byte, tbl[i].dout);
            chk($sformatf("pkt%0d_err", i), err_timeout, tbl[i].err);
            @(negedge clk);
        end
        bus.tx_accept = 1'b0;
        bus.tx_ready = 1'b1;

        // Rotation: two requesters held valid, single-byte packets.
        bus.req_valid = 4'b0101;
        bus.req_last = 4'b1111;
        bus.req_byte = 32'h44332211;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            wait_grant($sformatf("rot%0d_grant", k), k[0] ? 4'b0100 : 4'b0001);
            xfer($sformatf("rot%0d", k), k[0] ? 8'h33 : 8'h11);
        end

        // Lock: requester 3 arrives mid-packet and must wait for the last byte.
        bus.req_valid = 4'b0010;
        bus.req_last = 4'b0000;
        bus.req_byte = 32'hD4C3B2A1;
        do_reset();
        wait_grant("lock_grant0", 4'b0010);
        xfer("lock_b1", 8'hB2);
        bus.req_valid = 4'b1010;
        #1;
        chk("lock_grant1", grant, 4'b0010);
        xfer("lock_b2", 8'hB2);
        bus.req_last = 4'b0010;
        chk("lock_grant2", grant, 4'b0010);
        xfer("lock_b3", 8'hB2);
        chk("lock_idle", grant, 4'b0000);
        step();
        chk("lock_handoff", grant, 4'b1000);

        // Timeout: requester 2 sends one non-last byte then goes silent.
        bus.req_valid = 4'b0100;
        bus.req_last = 4'b0000;
        bus.req_byte = 32'h00110000;
        do_reset();
        wait_grant("to_grant", 4'b0100);
        xfer("to_b1", 8'h11);
        bus.req_valid = 4'b0000;
        #1;
        bad_err = 1'b0;
        for (int i = 1; i < 16; i++) begin
            bad_err |= err_timeout;
            step();
        end
        chk("to_early", bad_err, 0);
        chk("to_pulse", err_timeout, 1);
        chk("to_id", err_id, 2);
        step();
        chk("to_grant_clr", grant, 0);
        chk("to_pulse_end", err_timeout, 0);
        any_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            any_start |= bus.tx_start;
            step();
        end
        chk("to_no_start", any_start, 0);

        // Reset while LOAD holds tx_start; rr_ptr is 3 here and must return to 0.
        bus.req_valid = 4'b1000;
        bus.req_byte = 32'h7E000000;
        step();
        wait_grant("rl_grant", 4'b1000);
        for (int i = 0; i < 10 && !bus.tx_start; i++) step();
        chk("rl_start", bus.tx_start, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("rl_start_clr", bus.tx_start, 0);
        chk("rl_grant_clr", grant, 0);
        chk("rl_ready_clr", bus.req_ready, 0);
        chk("rl_byte_clr", bus.tx_byte, 0);
        @(negedge clk);
        @(negedge clk);
        bus.req_valid = 4'b1001;
        rstn = 1'b1;
        #1;
        wait_grant("rl_regrant", 4'b0001);

        // Stall: owner valid, uart busy for 40 cycles.
        bus.tx_ready = 1'b0;
        #1;
        bad_rdy = 1'b0;
        bad_err = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bad_rdy |= |bus.req_ready;
            bad_err |= err_timeout;
            step();
        end
        chk("stall_ready", bad_rdy, 0);
        chk("stall_err", bad_err, 0);
        chk("stall_grant", grant, 4'b0001);
        bus.tx_ready = 1'b1;
        #1;
        chk("stall_release", bus.req_ready, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
